// File: rtl/hdlc_tx_channel.sv
// hdlc_tx_channel: bit-level HDLC transmitter (flags, zero insertion, FCS, abort, idle fill).
module hdlc_tx_channel (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    FCS,
    END_FLAG,
    ABORT
  } state_t;

  localparam logic [7:0] FLAG = 8'h7E;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        rd_pend_q, rd_pend_d;
  logic [15:0] crc_q, crc_d;
  logic [2:0]  ones_q, ones_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic        active;
  logic        rd;
  logic        emit;
  logic        emit_bit;
  logic        emit_crc;
  logic [3:0]  nxt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // State register and datapath flops
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      crc_q       <= '0;
      ones_q      <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rd_pend_q   <= rd_pend_d;
      crc_q       <= crc_d;
      ones_q      <= ones_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic; registers describe the bit currently on the line,
  // so each branch computes the bit that goes out next.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    crc_d       = crc_q;
    ones_d      = ones_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    emit        = 1'b0;
    emit_bit    = 1'b0;
    emit_crc    = 1'b0;
    nxt         = cnt_q + 4'd1;

    active = (state_q == START_FLAG) || (state_q == DATA) ||
             (state_q == FCS) || (state_q == END_FLAG);
    rd = ((state_q == START_FLAG) || (state_q == DATA)) &&
         !hold_full_q && !rd_pend_q && Tx_DataAvail;
    rd_pend_d = rd;

    if (rd_pend_q) begin
      hold_d      = Tx_Data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d        = 1'b1;
        hold_full_d = 1'b0;
        rd_pend_d   = 1'b0;
        if (Tx_Enable && Tx_DataAvail) begin
          state_d   = START_FLAG;
          cnt_d     = '0;
          tx_d      = FLAG[0];
          crc_d     = '0;
          ones_d    = '0;
          aborted_d = 1'b0;
        end
      end
      START_FLAG: begin
        if (cnt_q != 4'd7) begin
          cnt_d = nxt;
          tx_d  = FLAG[nxt[2:0]];
        end else begin
          state_d     = DATA;
          cnt_d       = '0;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          emit        = 1'b1;
          emit_bit    = hold_q[0];
          emit_crc    = 1'b1;
        end
      end
      DATA: begin
        if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = '0;
        end else if (cnt_q != 4'd7) begin
          cnt_d    = nxt;
          shift_d  = shift_q >> 1;
          emit     = 1'b1;
          emit_bit = shift_q[1];
          emit_crc = 1'b1;
        end else if (hold_full_q) begin
          cnt_d       = '0;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          emit        = 1'b1;
          emit_bit    = hold_q[0];
          emit_crc    = 1'b1;
        end else if (rd_pend_q) begin
          // Read data arriving exactly at the boundary bypasses the holding register.
          cnt_d       = '0;
          shift_d     = Tx_Data;
          hold_full_d = 1'b0;
          emit        = 1'b1;
          emit_bit    = Tx_Data[0];
          emit_crc    = 1'b1;
        end else begin
          // Nothing buffered at the boundary: the data field ends here.
          state_d  = FCS;
          cnt_d    = '0;
          emit     = 1'b1;
          emit_bit = crc_q[15];
        end
      end
      FCS: begin
        if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = '0;
        end else if (cnt_q != 4'd15) begin
          cnt_d    = nxt;
          crc_d    = {crc_q[14:0], 1'b0};
          emit     = 1'b1;
          emit_bit = crc_q[14];
        end else begin
          state_d = END_FLAG;
          cnt_d   = '0;
          tx_d    = FLAG[0];
          ones_d  = '0;
        end
      end
      END_FLAG: begin
        if (cnt_q != 4'd7) begin
          cnt_d = nxt;
          tx_d  = FLAG[nxt[2:0]];
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      ABORT: begin
        tx_d = 1'b1;
        if (cnt_q != 4'd7) begin
          cnt_d = nxt;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (emit) begin
      tx_d   = emit_bit;
      ones_d = emit_bit ? (ones_q + 3'd1) : 3'd0;
      if (emit_crc) begin
        crc_d = crc_step(crc_q, emit_bit);
      end
    end

    // Abort overrides whatever the active state decided this cycle.
    if (active && Tx_AbortFrame) begin
      state_d     = ABORT;
      cnt_d       = '0;
      tx_d        = 1'b0;
      ones_d      = '0;
      done_d      = 1'b0;
      aborted_d   = 1'b1;
      hold_full_d = 1'b0;
      rd_pend_d   = 1'b0;
    end
  end

  assign Tx              = tx_q;
  assign Tx_RdBuff       = rd;
  assign Tx_ValidFrame   = active;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// tb_hdlc_tx_channel: scoreboard bench for the HDLC transmitter.
module tb_hdlc_tx_channel;

  logic       clk;
  logic       Rst;
  logic       Tx_Enable;
  logic       Tx_AbortFrame;
  logic       Tx_DataAvail;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;

  logic exp_q[$];
  logic line_log[$];

  logic [7:0]  mem [16];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  logic [7:0] fb [4];
  int unsigned fn;

  hdlc_tx_channel dut (
    .Clk            (clk),
    .Rst            (Rst),
    .Tx_Enable      (Tx_Enable),
    .Tx_AbortFrame  (Tx_AbortFrame),
    .Tx_DataAvail   (Tx_DataAvail),
    .Tx_Data        (Tx_Data),
    .Tx_RdBuff      (Tx_RdBuff),
    .Tx             (Tx),
    .Tx_ValidFrame  (Tx_ValidFrame),
    .Tx_Done        (Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Tx_DataAvail = (rd_ptr != wr_ptr);

  // Tx buffer model: one-cycle read latency
  initial begin
    Tx_Data = 8'h00;
    forever begin
      @(posedge clk);
      if (Tx_RdBuff === 1'b1) begin
        Tx_Data <= mem[rd_ptr[3:0]];
        rd_ptr  <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected line bit per cycle of Tx_ValidFrame
  initial begin
    logic eb;
    forever begin
      @(negedge clk);
      if (Tx_RdBuff === 1'b1) rd_cnt++;
      if (Tx_Done === 1'b1) done_cnt++;
      if (Tx_ValidFrame === 1'b1) begin
        valid_cnt++;
        line_log.push_back(Tx);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_bit: got %0b expected no bit", Tx);
        end else begin
          eb = exp_q.pop_front();
          chk("tx_bit", {31'd0, Tx}, {31'd0, eb});
        end
      end
    end
  end

  task automatic load_buffer();
    for (int unsigned k = 0; k < fn; k++) begin
      mem[wr_ptr[3:0]] = fb[k];
      wr_ptr++;
    end
  endtask

  task automatic flush_buffer();
    wr_ptr = rd_ptr;
  endtask

  // Expected line bits for the frame in fb/fn; only the first 'limit' are queued.
  task automatic build_expected(input int unsigned limit);
    logic        raw[$];
    logic        q[$];
    logic [7:0]  flag;
    logic [15:0] c;
    logic        b;
    int unsigned ones;
    flag = 8'h7E;
    c = 16'h0000;
    for (int unsigned k = 0; k < fn; k++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        b = fb[k][i];
        raw.push_back(b);
        c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
      end
    end
    for (int unsigned i = 0; i < 16; i++) raw.push_back(c[15 - i]);
    for (int unsigned i = 0; i < 8; i++) q.push_back(flag[i]);
    ones = 0;
    foreach (raw[i]) begin
      q.push_back(raw[i]);
      if (raw[i]) begin
        ones++;
        if (ones == 5) begin
          q.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    for (int unsigned i = 0; i < 8; i++) q.push_back(flag[i]);
    for (int unsigned i = 0; i < q.size() && i < limit; i++) exp_q.push_back(q[i]);
  endtask

  // Receiver view of line_log: flags, destuffing, byte recovery, CRC residue
  task automatic rx_check(input string name);
    logic        d[$];
    logic [15:0] c;
    logic [7:0]  f0;
    logic [7:0]  f1;
    logic [7:0]  rb;
    logic        b;
    int unsigned n;
    int unsigned ones;
    int unsigned run;
    int unsigned maxrun;
    n = line_log.size();
    chk({name, "_len_min"}, {31'd0, n >= 16}, 32'd1);
    if (n < 16) return;
    for (int unsigned i = 0; i < 8; i++) begin
      f0[i] = line_log[i];
      f1[i] = line_log[n - 8 + i];
    end
    chk({name, "_open_flag"}, {24'd0, f0}, 32'h7E);
    chk({name, "_close_flag"}, {24'd0, f1}, 32'h7E);
    c = 16'h0000;
    ones = 0;
    run = 0;
    maxrun = 0;
    for (int unsigned i = 8; i < n - 8; i++) begin
      b = line_log[i];
      run = b ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (ones == 5) begin
        ones = 0;
      end else begin
        d.push_back(b);
        c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
        ones = b ? ones + 1 : 0;
      end
    end
    chk({name, "_no_six_ones"}, {31'd0, maxrun <= 5}, 32'd1);
    chk({name, "_crc_residue"}, {16'd0, c}, 32'h0);
    chk({name, "_destuffed_len"}, d.size(), 8 * fn + 16);
    if (d.size() >= 8 * fn) begin
      for (int unsigned k = 0; k < fn; k++) begin
        for (int unsigned i = 0; i < 8; i++) rb[i] = d[8 * k + i];
        chk({name, "_rx_byte"}, {24'd0, rb}, {24'd0, fb[k]});
      end
    end
  endtask

  // Pulse Tx_Enable for edge E0; returns in cycle 1 after checking it.
  task automatic start_frame(input string name);
    @(posedge clk);
    #1 Tx_Enable = 1'b1;
    @(posedge clk);
    #1 Tx_Enable = 1'b0;
    chk({name, "_c1_tx"}, {31'd0, Tx}, 32'd0);
    chk({name, "_c1_valid"}, {31'd0, Tx_ValidFrame}, 32'd1);
    chk({name, "_c1_rdbuff"}, {31'd0, Tx_RdBuff}, 32'd1);
    chk({name, "_c1_aborted"}, {31'd0, Tx_AbortedTrans}, 32'd0);
  endtask

  task automatic wait_done(input string name);
    int unsigned k;
    k = 0;
    while (Tx_Done !== 1'b1 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_done_seen"}, {31'd0, Tx_Done}, 32'd1);
    chk({name, "_done_valid_low"}, {31'd0, Tx_ValidFrame}, 32'd0);
    chk({name, "_done_tx_idle"}, {31'd0, Tx}, 32'd1);
    @(posedge clk);
    #1;
    chk({name, "_done_one_cycle"}, {31'd0, Tx_Done}, 32'd0);
  endtask

  initial begin
    int          rd0;
    int          dn0;
    int          vl0;
    logic [63:0] v;
    logic [8:0]  v9;

    Rst = 1'b1;
    Tx_Enable = 1'b0;
    Tx_AbortFrame = 1'b0;
    fn = 0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, Tx}, 32'd1);
    chk("rst_rdbuff", {31'd0, Tx_RdBuff}, 32'd0);
    chk("rst_valid", {31'd0, Tx_ValidFrame}, 32'd0);
    chk("rst_done", {31'd0, Tx_Done}, 32'd0);
    chk("rst_aborted", {31'd0, Tx_AbortedTrans}, 32'd0);
    Rst = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 chk("idle_tx", {31'd0, Tx}, 32'd1);
    end

    // One-byte 0x00 frame
    fb[0] = 8'h00; fn = 1;
    line_log.delete();
    rd0 = rd_cnt; dn0 = done_cnt; vl0 = valid_cnt;
    load_buffer();
    build_expected(1000);
    start_frame("f00");
    wait_done("f00");
    repeat (3) @(posedge clk);
    #1;
    chk("f00_valid_cycles", valid_cnt - vl0, 40);
    chk("f00_rd_pulses", rd_cnt - rd0, 1);
    chk("f00_done_pulses", done_cnt - dn0, 1);
    chk("f00_exp_left", exp_q.size(), 0);
    v = '0;
    for (int unsigned i = 0; i < line_log.size() && i < 64; i++) v[i] = line_log[i];
    chk("f00_line_lo", v[31:0], 32'h0000007E);
    chk("f00_line_hi", v[63:32], 32'h0000007E);
    rx_check("f00");

    // Zero insertion with 0xFF
    fb[0] = 8'hFF; fn = 1;
    line_log.delete();
    rd0 = rd_cnt; dn0 = done_cnt;
    load_buffer();
    build_expected(1000);
    start_frame("fff");
    wait_done("fff");
    chk("fff_rd_pulses", rd_cnt - rd0, 1);
    chk("fff_done_pulses", done_cnt - dn0, 1);
    chk("fff_exp_left", exp_q.size(), 0);
    v9 = '0;
    for (int unsigned j = 0; j < 9; j++) if (line_log.size() > 8 + j) v9[j] = line_log[8 + j];
    chk("fff_data_field", {23'd0, v9}, 32'h1DF);
    rx_check("fff");

    // Abort in the 4th data bit
    fb[0] = 8'hA5; fb[1] = 8'h3C; fn = 2;
    line_log.delete();
    rd0 = rd_cnt; dn0 = done_cnt;
    load_buffer();
    build_expected(12);
    start_frame("abt");
    repeat (11) @(posedge clk);
    #1 Tx_AbortFrame = 1'b1;
    @(posedge clk);
    #1 Tx_AbortFrame = 1'b0;
    chk("abt_first_zero", {31'd0, Tx}, 32'd0);
    chk("abt_valid_low", {31'd0, Tx_ValidFrame}, 32'd0);
    chk("abt_aborted_set", {31'd0, Tx_AbortedTrans}, 32'd1);
    for (int unsigned i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 chk("abt_one", {31'd0, Tx}, 32'd1);
    end
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk("abt_idle_tx", {31'd0, Tx}, 32'd1);
    end
    chk("abt_valid_idle", {31'd0, Tx_ValidFrame}, 32'd0);
    chk("abt_rd_pulses", rd_cnt - rd0, 2);
    chk("abt_no_done", done_cnt - dn0, 0);
    chk("abt_exp_left", exp_q.size(), 0);
    chk("abt_aborted_hold", {31'd0, Tx_AbortedTrans}, 32'd1);
    flush_buffer();

    // Tx_Enable with empty buffer is ignored
    rd0 = rd_cnt; vl0 = valid_cnt;
    @(posedge clk);
    #1 Tx_Enable = 1'b1;
    @(posedge clk);
    #1 Tx_Enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("noav_valid_cycles", valid_cnt - vl0, 0);
    chk("noav_rd_pulses", rd_cnt - rd0, 0);
    chk("noav_tx", {31'd0, Tx}, 32'd1);
    chk("noav_aborted_hold", {31'd0, Tx_AbortedTrans}, 32'd1);

    // Multi-byte frame 0x7E 0xFF 0x01
    fb[0] = 8'h7E; fb[1] = 8'hFF; fb[2] = 8'h01; fn = 3;
    line_log.delete();
    rd0 = rd_cnt; dn0 = done_cnt;
    load_buffer();
    build_expected(1000);
    start_frame("f3");
    wait_done("f3");
    chk("f3_rd_pulses", rd_cnt - rd0, 3);
    chk("f3_done_pulses", done_cnt - dn0, 1);
    chk("f3_exp_left", exp_q.size(), 0);
    rx_check("f3");

    // Reset during FCS
    fb[0] = 8'h00; fn = 1;
    line_log.delete();
    dn0 = done_cnt;
    load_buffer();
    build_expected(20);
    start_frame("rfcs");
    repeat (19) @(posedge clk);
    #1 Rst = 1'b1;
    @(posedge clk);
    #1 Rst = 1'b0;
    chk("rfcs_tx", {31'd0, Tx}, 32'd1);
    chk("rfcs_valid", {31'd0, Tx_ValidFrame}, 32'd0);
    chk("rfcs_aborted", {31'd0, Tx_AbortedTrans}, 32'd0);
    repeat (50) @(posedge clk);
    #1;
    chk("rfcs_no_done", done_cnt - dn0, 0);
    chk("rfcs_exp_left", exp_q.size(), 0);
    chk("rfcs_idle_tx", {31'd0, Tx}, 32'd1);
    flush_buffer();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
